// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR with decimate-by-2, built on one serial MAC engine.
// A 16-tap symmetric Q1.15 coefficient ROM is applied to a circular delay line on every second accepted sample.
module cic_comp_fir #(
  parameter int DW   = 20,
  parameter int CW   = 16,
  parameter int NTAP = 16,
  parameter int AW   = 40
) (
  input  logic                 clki,
  input  logic                 rst,
  input  logic                 din_vld,
  input  logic signed [DW-1:0] din,
  output logic                 dout_vld,
  output logic signed [DW-1:0] dout,
  output logic                 busy,
  output logic                 ovf_err,
  output logic                 sat_flag,
  input  logic                 clr_err
);

  typedef enum logic [1:0] {IDLE, WRITE, MAC, RND} state_t;

  localparam logic [3:0] KLAST = 4'(NTAP - 1);
  localparam logic signed [AW-1:0] RND_HALF = {{(AW-CW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}};
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t state, state_nxt;

  logic signed [DW-1:0]    dly [NTAP];
  logic [3:0]              wptr;
  logic [3:0]              k;
  logic                    phase;
  logic signed [DW-1:0]    pend;
  logic                    pend_vld;
  logic signed [AW-1:0]    acc;

  logic [3:0]              rd_idx;
  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    acc_rnd;
  logic signed [DW-1:0]    dout_nxt;
  logic                    sat_set;
  logic                    take;
  logic                    ovf_set;

  function automatic logic signed [CW-1:0] coef(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd15: coef = -16'sd64;
      4'd1, 4'd14: coef = -16'sd192;
      4'd2, 4'd13: coef = 16'sd256;
      4'd3, 4'd12: coef = 16'sd1024;
      4'd4, 4'd11: coef = -16'sd512;
      4'd5, 4'd10: coef = -16'sd2048;
      4'd6, 4'd9:  coef = 16'sd3072;
      default:     coef = 16'sd14848;
    endcase
  endfunction

  // Tap k reads the sample k positions older than the newest one (wptr already advanced).
  assign rd_idx   = wptr - 4'd1 - k;
  assign prod     = dly[rd_idx] * coef(k);
  assign prod_ext = {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
  assign acc_rnd  = (acc + RND_HALF) >>> (CW - 1);

  always_comb begin
    sat_set  = 1'b0;
    dout_nxt = acc_rnd[DW-1:0];
    if (acc_rnd > MAXV) begin
      dout_nxt = MAXV[DW-1:0];
      sat_set  = 1'b1;
    end else if (acc_rnd < MINV) begin
      dout_nxt = MINV[DW-1:0];
      sat_set  = 1'b1;
    end
  end

  // The pending slot is freed in WRITE, so a strobe landing in that same cycle refills it.
  assign take    = (state == WRITE);
  assign ovf_set = din_vld && pend_vld && !take;

  always_ff @(posedge clki) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (din_vld || pend_vld) state_nxt = WRITE;
      WRITE:   state_nxt = phase ? MAC : IDLE;
      MAC:     if (k == KLAST) state_nxt = RND;
      RND:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) dly[i] <= '0;
      wptr     <= '0;
      k        <= '0;
      phase    <= 1'b0;
      pend     <= '0;
      pend_vld <= 1'b0;
      acc      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf_err  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      dout_vld <= 1'b0;

      if (din_vld && (!pend_vld || take)) begin
        pend     <= din;
        pend_vld <= 1'b1;
      end else if (take) begin
        pend_vld <= 1'b0;
      end

      case (state)
        WRITE: begin
          dly[wptr] <= pend;
          wptr      <= wptr + 4'd1;
          phase     <= ~phase;
          acc       <= '0;
          k         <= '0;
        end
        MAC: begin
          acc <= acc + prod_ext;
          k   <= k + 4'd1;
        end
        RND: begin
          dout     <= dout_nxt;
          dout_vld <= 1'b1;
        end
        default: ;
      endcase

      if (ovf_set)      ovf_err <= 1'b1;
      else if (clr_err) ovf_err <= 1'b0;

      if ((state == RND) && sat_set) sat_flag <= 1'b1;
      else if (clr_err)              sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: impulse, DC, saturation, overflow, latency and mid-MAC reset.
// Expected values come from the coefficient table and the round-half-up rule, worked by hand.
module tb_cic_comp_fir;

  logic               clki = 1'b0;
  logic               rst = 1'b1;
  logic               din_vld = 1'b0;
  logic signed [19:0] din = '0;
  logic               dout_vld;
  logic signed [19:0] dout;
  logic               busy;
  logic               ovf_err;
  logic               sat_flag;
  logic               clr_err = 1'b0;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int base;
  logic signed [31:0] last_dout = '0;

  int imp_exp[10] = '{-192, 1024, -2048, 14848, 3072, -512, 256, -64, 0, 0};
  int dc_exp[8]   = '{-781, 3125, -4687, 50000, 104688, 96875, 100781, 100000};
  bit csign[16]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  cic_comp_fir dut (
    .clki     (clki),
    .rst      (rst),
    .din_vld  (din_vld),
    .din      (din),
    .dout_vld (dout_vld),
    .dout     (dout),
    .busy     (busy),
    .ovf_err  (ovf_err),
    .sat_flag (sat_flag),
    .clr_err  (clr_err)
  );

  always #5 clki = ~clki;

  always @(negedge clki) begin
    if (dout_vld === 1'b1) begin
      vld_cnt   = vld_cnt + 1;
      last_dout = dout;
    end
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clki);
    rst = 1'b1;
    repeat (2) @(negedge clki);
    rst = 1'b0;
  endtask

  task automatic send(input int v, input int gap);
    @(negedge clki);
    din     = 20'(v);
    din_vld = 1'b1;
    @(negedge clki);
    din_vld = 1'b0;
    repeat (gap) @(negedge clki);
  endtask

  task automatic pulse_clr();
    @(negedge clki);
    clr_err = 1'b1;
    @(negedge clki);
    clr_err = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clki);
    rst = 1'b0;
    @(negedge clki);
    check("rst_dout", dout, 0);
    check("rst_vld", dout_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_sat", sat_flag, 0);

    // Impulse response, one output per two samples
    do_reset();
    base = vld_cnt;
    for (int i = 0; i < 20; i++) begin
      send((i == 0) ? 32768 : 0, 249);
      if (i % 2 == 1) begin
        check("imp_cnt", vld_cnt - base, i / 2 + 1);
        check("imp_val", last_dout, imp_exp[i / 2]);
      end
    end

    // DC step: partial coefficient sums until the delay line fills
    do_reset();
    base = vld_cnt;
    for (int i = 0; i < 40; i++) begin
      send(100000, 24);
      if (i % 2 == 1) begin
        check("dc_cnt", vld_cnt - base, i / 2 + 1);
        check("dc_val", last_dout, (i / 2 < 8) ? dc_exp[i / 2] : 100000);
      end
    end
    check("dc_sat", sat_flag, 0);

    // Positive saturation: every product positive
    do_reset();
    for (int i = 0; i < 16; i++) send(csign[i] ? -524287 : 524287, 24);
    check("satp_val", last_dout, 524287);
    check("satp_flag", sat_flag, 1);
    pulse_clr();
    check("satp_clr", sat_flag, 0);

    // Negative saturation
    do_reset();
    for (int i = 0; i < 16; i++) send(csign[i] ? 524287 : -524287, 24);
    check("satn_val", last_dout, -524288);
    check("satn_flag", sat_flag, 1);

    // Overflow: trigger at T, accepted sample at T+3, dropped sample at T+5
    do_reset();
    check("satn_rst", sat_flag, 0);
    base = vld_cnt;
    send(32768, 24);
    @(negedge clki); din = 20'sd0; din_vld = 1'b1;
    @(negedge clki); din_vld = 1'b0;
    @(negedge clki);
    @(negedge clki); din = 20'sd32768; din_vld = 1'b1;
    @(negedge clki); din_vld = 1'b0;
    check("ovf_pre", ovf_err, 0);
    @(negedge clki); din = 20'sd32768; din_vld = 1'b1;
    @(negedge clki); din_vld = 1'b0;
    check("ovf_set", ovf_err, 1);
    repeat (40) @(negedge clki);
    check("ovf_cnt1", vld_cnt - base, 1);
    check("ovf_val1", last_dout, -192);
    send(0, 24);
    check("ovf_cnt2", vld_cnt - base, 2);
    check("ovf_val2", last_dout, 832);
    pulse_clr();
    check("ovf_clr", ovf_err, 0);

    // Latency: odd sample gives no strobe, trigger strobes at T+19 only
    do_reset();
    base = vld_cnt;
    send(32768, 24);
    check("lat_odd", vld_cnt - base, 0);
    @(negedge clki); din = 20'sd0; din_vld = 1'b1;
    @(negedge clki); din_vld = 1'b0;
    for (int j = 1; j <= 21; j++) begin
      if (j > 1) @(negedge clki);
      check($sformatf("lat_busy_%0d", j), busy, (j <= 18) ? 1 : 0);
      check($sformatf("lat_vld_%0d", j), dout_vld, (j == 19) ? 1 : 0);
    end
    check("lat_cnt", vld_cnt - base, 1);
    check("lat_val", dout, -192);

    // Reset asserted on edge T+8 of a computation
    base = vld_cnt;
    send(32768, 24);
    @(negedge clki); din = 20'sd0; din_vld = 1'b1;
    @(negedge clki); din_vld = 1'b0;
    repeat (7) @(negedge clki);
    rst = 1'b1;
    @(negedge clki);
    rst = 1'b0;
    check("mrst_dout", dout, 0);
    check("mrst_busy", busy, 0);
    check("mrst_vld", dout_vld, 0);
    repeat (30) @(negedge clki);
    check("mrst_nostrobe", vld_cnt - base, 0);
    send(32768, 24);
    send(0, 24);
    check("mrst_cnt", vld_cnt - base, 1);
    check("mrst_val", last_dout, -192);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
